gpio_seq_ctrl: RTL and testbench
================================

Name: gpio_seq_ctrl

Overview:
- Pattern sequencer and bus arbiter in front of the gpio peripheral's register port.
- Plays a CPU-loaded table of {pattern, delay} steps into GPIO DATA_OUT (offset 0x00) with cycle-accurate spacing, optionally looping.
- Shares the single gpio bus port between CPU pass-through (priority) and the sequencer master.
- Raises an interrupt when a non-looping run completes.

Parameters:
- DEPTH, 8, number of table steps (power of 2, 2..16).
- DLY_W, 16, width of per-step delay field.
- IW, $clog2(DEPTH), step index width (derived, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- s_addr  in  8  sequencer register byte offset.
- s_wr_en / s_rd_en  in  1  sequencer register write/read strobes.
- s_wdata  in  32  sequencer register write data.
- s_rdata  out  32  sequencer register read data (combinational, 0 when !s_rd_en).
- c_addr, c_wr_en, c_rd_en, c_wdata  in  8/1/1/32  CPU access to the gpio peripheral.
- c_rdata  out  32  = m_rdata (pass-through).
- m_addr, m_wr_en, m_rd_en, m_wdata  out  8/1/1/32  to the gpio peripheral bus port.
- m_rdata  in  32  from the gpio peripheral.
- irq  out  1  done & CTRL.IE.

Behaviour:
- Reset: state IDLE; step=0; cnt=0; CTRL=0; done=0; idx=0; table contents undefined. All m_* outputs 0, irq 0.
- Registers, decoded on s_addr[4:2]:
  - 0x00 CTRL: [0] START (W1, self-clear, reads 0); [1] LOOP; [2] STOP (W1, reads 0); [3] IE; [8+:IW] LEN = last step index.
  - 0x04 STATUS (RO except W1C): [0] busy (state!=IDLE); [1] done (sticky, write 1 to clear); [8+:IW] current step.
  - 0x08 IDX: table pointer, R/W, lower IW bits.
  - 0x0C PAT: R/W pattern[IDX].
  - 0x10 DLY: R/W delay[IDX]; a DLY write also sets IDX=IDX+1, wrapping at DEPTH.
- Arbitration (combinational): if c_wr_en|c_rd_en, m_* = c_*. Otherwise m_* = sequencer drive when in ISSUE, else 0. The CPU always wins; the sequencer write is deferred, never dropped.
- FSM:
  - IDLE: START -> ISSUE with step=0. START while busy is ignored.
  - ISSUE: if the CPU is idle this cycle, drive m_wr_en=1, m_addr=0x00, m_wdata=pattern[step]; load cnt=delay[step]; go to WAIT. If the CPU is active, stay in ISSUE.
  - WAIT: if cnt!=0, cnt--. If cnt==0:
    - step!=LEN: step++, go to ISSUE.
    - step==LEN and LOOP=1: step=0, go to ISSUE.
    - otherwise: go to IDLE and set done=1.
- Timing: with no contention, a write at cycle t gives the next write at t+delay+2. Delay 0 gives 2-cycle spacing.
- STOP: from any state, go to IDLE next cycle. No further m_wr_en. done is unchanged. STOP and START in the same write: STOP wins.
- LOOP cleared mid-run: the run ends after the current pass.
- Table/LEN writes while busy are allowed. pattern/delay are sampled at ISSUE; LEN is sampled at the step==LEN compare.
- done set and W1C in the same cycle: set wins.
- Reset mid-run: immediate return to reset state. No partial bus write is emitted after rst rises.

Optional Feature:
- Macro GPIO_SEQ_TRIG_EN.
- When defined:
  - Adds input port seq_trig (1 bit, already synchronous to clk).
  - Adds CTRL[4] ARM.
  - A rising edge of seq_trig (registered previous value) while IDLE and ARM=1 acts exactly as START and clears ARM.
- When undefined: no port, CTRL[4] reads 0 and ignores writes.

Decomposition:
- Package gpio_seq_pkg holds:
  - Register offsets (SEQ_CTRL=0x00, SEQ_STATUS=0x04, SEQ_IDX=0x08, SEQ_PAT=0x0C, SEQ_DLY=0x10).
  - CTRL/STATUS bit positions.
  - GPIO_DATA_OUT_OFS=0x00.
  - seq_state_t enum {IDLE, ISSUE, WAIT}.
- Sub-module: none required. The table (DEPTH x (32+DLY_W)) is a local register array in gpio_seq_ctrl.

Test Plan:
1. Load PAT={0xA,0x5,0xF}, DLY={0,3,1}, LEN=2, START -> m_wdata 0xA,0x5,0xF at cycles t, t+2, t+7; then done=1, busy=0; irq=1 if IE=1.
2. Same table with LOOP=1 -> after 0xF, 0xA reissued at t+10. Write STOP -> no m_wr_en thereafter, done stays 0.
3. Hold c_wr_en=1 for 4 cycles at the scheduled ISSUE cycle -> m_* mirror the CPU; the sequencer write appears in the first cycle c_wr_en=0; later spacing is unchanged relative to that write.
4. Write STATUS=0x2 in the cycle done is being set -> done reads 1. Next STATUS=0x2 -> done=0, irq=0.
5. Assert rst during WAIT of step 1 -> next cycle busy=0, step=0, m_wr_en=0, irq=0. START then replays from step 0.
6. GPIO_SEQ_TRIG_EN defined, ARM=1, seq_trig 0->1 -> run starts, ARM reads 0. A second edge while busy is ignored.

Source files
------------

// File: rtl/gpio_seq_pkg.sv
// Shared definitions for the gpio pattern sequencer: register map, CTRL/STATUS
// bit positions, the gpio DATA_OUT offset the sequencer writes to, and FSM states.
// No ports; imported by gpio_seq_ctrl and its bench.
package gpio_seq_pkg;

    // Sequencer register byte offsets (decoded on addr[4:2])
    localparam logic [7:0] SEQ_CTRL   = 8'h00;
    localparam logic [7:0] SEQ_STATUS = 8'h04;
    localparam logic [7:0] SEQ_IDX    = 8'h08;
    localparam logic [7:0] SEQ_PAT    = 8'h0C;
    localparam logic [7:0] SEQ_DLY    = 8'h10;

    // gpio peripheral register the sequencer drives
    localparam logic [7:0] GPIO_DATA_OUT_OFS = 8'h00;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_STOP  = 2;
    localparam int CTRL_IE    = 3;
    localparam int CTRL_ARM   = 4;
    localparam int CTRL_LEN   = 8;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_STEP = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // Word select used by the register decoder
    function automatic logic [2:0] reg_sel(input logic [7:0] ofs);
        return ofs[4:2];
    endfunction

endpackage

// File: rtl/gpio_seq_ctrl.sv
// Pattern sequencer + arbiter in front of the gpio register port: plays a
// table of {pattern, delay} steps into gpio DATA_OUT, CPU pass-through has priority.
// Latency: bus mux is combinational; step writes spaced delay+2 cycles apart.
// Backpressure: CPU access in the issue cycle defers (never drops) the sequencer write.
// Ports: clk/rst; s_* sequencer register port; c_* CPU gpio access; m_* gpio bus
// master; irq = done & CTRL.IE.
// Optional macro GPIO_SEQ_TRIG_EN: adds seq_trig input and CTRL.ARM trigger start.
module gpio_seq_ctrl
    import gpio_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DLY_W = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef GPIO_SEQ_TRIG_EN
    input  logic        seq_trig,
`endif
    input  logic [7:0]  s_addr,
    input  logic        s_wr_en,
    input  logic        s_rd_en,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    input  logic [7:0]  c_addr,
    input  logic        c_wr_en,
    input  logic        c_rd_en,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic [7:0]  m_addr,
    output logic        m_wr_en,
    output logic        m_rd_en,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] SEL_CTRL   = reg_sel(SEQ_CTRL);
    localparam logic [2:0] SEL_STATUS = reg_sel(SEQ_STATUS);
    localparam logic [2:0] SEL_IDX    = reg_sel(SEQ_IDX);
    localparam logic [2:0] SEL_PAT    = reg_sel(SEQ_PAT);
    localparam logic [2:0] SEL_DLY    = reg_sel(SEQ_DLY);

    seq_state_t        state, state_nxt;
    logic [IW-1:0]     step, step_nxt;
    logic [DLY_W-1:0]  cnt, cnt_nxt;
    logic              loop_en, ie, done;
    logic [IW-1:0]     len, idx;
    logic              done_set, seq_wr, seq_drive;
    logic              arm_bit, trig_start;

    logic [31:0]       pat_tab [DEPTH];
    logic [DLY_W-1:0]  dly_tab [DEPTH];

    // Only addr[4:2] selects a register; the other address bits alias.
    logic unused_addr;
    assign unused_addr = ^{s_addr[7:5], s_addr[1:0]};

    logic [2:0] sel;
    logic wr_ctrl, wr_stat, wr_idx, wr_pat, wr_dly;
    logic start_wr, stop_wr, w1c_done;

    assign sel      = s_addr[4:2];
    assign wr_ctrl  = s_wr_en && (sel == SEL_CTRL);
    assign wr_stat  = s_wr_en && (sel == SEL_STATUS);
    assign wr_idx   = s_wr_en && (sel == SEL_IDX);
    assign wr_pat   = s_wr_en && (sel == SEL_PAT);
    assign wr_dly   = s_wr_en && (sel == SEL_DLY);
    assign start_wr = wr_ctrl && s_wdata[CTRL_START];
    assign stop_wr  = wr_ctrl && s_wdata[CTRL_STOP];
    assign w1c_done = wr_stat && s_wdata[STAT_DONE];

    logic cpu_act;
    assign cpu_act = c_wr_en | c_rd_en;

`ifdef GPIO_SEQ_TRIG_EN
    logic trig_q;
    // Rising edge of the (already synchronous) trigger acts as START.
    assign trig_start = seq_trig && !trig_q && arm_bit && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q  <= 1'b0;
            arm_bit <= 1'b0;
        end else begin
            trig_q <= seq_trig;
            if (wr_ctrl)
                arm_bit <= s_wdata[CTRL_ARM];
            else if (trig_start)
                arm_bit <= 1'b0;
        end
    end
`else
    assign trig_start = 1'b0;
    assign arm_bit    = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        cnt_nxt   = cnt;
        done_set  = 1'b0;
        seq_wr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_wr || trig_start) begin
                    state_nxt = ISSUE;
                    step_nxt  = '0;
                end
            end
            ISSUE: begin
                // Wait out any CPU access; the write happens in the first free cycle.
                if (!cpu_act) begin
                    seq_wr    = 1'b1;
                    cnt_nxt   = dly_tab[step];
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - DLY_W'(1);
                end else if (step != len) begin
                    step_nxt  = step + IW'(1);
                    state_nxt = ISSUE;
                end else if (loop_en) begin
                    step_nxt  = '0;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // STOP overrides everything, including a same-cycle START or issue.
        if (stop_wr) begin
            state_nxt = IDLE;
            seq_wr    = 1'b0;
            done_set  = 1'b0;
        end
    end

    // Reset also masks the drive so no write leaks out while rst is high.
    assign seq_drive = seq_wr && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            step    <= '0;
            cnt     <= '0;
            loop_en <= 1'b0;
            ie      <= 1'b0;
            len     <= '0;
            done    <= 1'b0;
            idx     <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            cnt   <= cnt_nxt;
            // A completion in the same cycle as a clear keeps done set.
            done  <= done_set | (done & ~w1c_done);
            if (wr_ctrl) begin
                loop_en <= s_wdata[CTRL_LOOP];
                ie      <= s_wdata[CTRL_IE];
                len     <= s_wdata[CTRL_LEN +: IW];
            end
            if (wr_idx)
                idx <= s_wdata[IW-1:0];
            else if (wr_dly)
                idx <= idx + IW'(1);
        end
    end

    // Table storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_pat)
            pat_tab[idx] <= s_wdata;
        if (wr_dly)
            dly_tab[idx] <= s_wdata[DLY_W-1:0];
    end

    // Register read mux
    always_comb begin
        s_rdata = '0;
        if (s_rd_en) begin
            unique case (sel)
                SEL_CTRL: begin
                    s_rdata[CTRL_LOOP]       = loop_en;
                    s_rdata[CTRL_IE]         = ie;
                    s_rdata[CTRL_ARM]        = arm_bit;
                    s_rdata[CTRL_LEN +: IW]  = len;
                end
                SEL_STATUS: begin
                    s_rdata[STAT_BUSY]       = (state != IDLE);
                    s_rdata[STAT_DONE]       = done;
                    s_rdata[STAT_STEP +: IW] = step;
                end
                SEL_IDX: s_rdata[IW-1:0]    = idx;
                SEL_PAT: s_rdata            = pat_tab[idx];
                SEL_DLY: s_rdata[DLY_W-1:0] = dly_tab[idx];
                default: s_rdata = '0;
            endcase
        end
    end

    // Bus arbitration: CPU first, then the sequencer issue, else idle.
    always_comb begin
        m_addr  = '0;
        m_wr_en = 1'b0;
        m_rd_en = 1'b0;
        m_wdata = '0;
        if (cpu_act) begin
            m_addr  = c_addr;
            m_wr_en = c_wr_en;
            m_rd_en = c_rd_en;
            m_wdata = c_wdata;
        end else if (seq_drive) begin
            m_addr  = GPIO_DATA_OUT_OFS;
            m_wr_en = 1'b1;
            m_wdata = pat_tab[step];
        end
    end

    assign c_rdata = m_rdata;
    assign irq     = done & ie;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Bench for gpio_seq_ctrl: randomized tables and CPU bursts; expected gpio
// writes (cycle, data) come from a timing model and are queued; a negedge
// monitor pops and compares every sequencer write and mirrors CPU accesses.
module tb_gpio_seq_ctrl;
    import gpio_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int DLY_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        seq_trig;
    logic [7:0]  s_addr;
    logic        s_wr_en, s_rd_en;
    logic [31:0] s_wdata, s_rdata;
    logic [7:0]  c_addr;
    logic        c_wr_en, c_rd_en;
    logic [31:0] c_wdata, c_rdata;
    logic [7:0]  m_addr;
    logic        m_wr_en, m_rd_en;
    logic [31:0] m_wdata, m_rdata;
    logic        irq;

    gpio_seq_ctrl #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
        .clk(clk), .rst(rst),
`ifdef GPIO_SEQ_TRIG_EN
        .seq_trig(seq_trig),
`endif
        .s_addr(s_addr), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
        .s_wdata(s_wdata), .s_rdata(s_rdata),
        .c_addr(c_addr), .c_wr_en(c_wr_en), .c_rd_en(c_rd_en),
        .c_wdata(c_wdata), .c_rdata(c_rdata),
        .m_addr(m_addr), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) m_rdata <= $urandom;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    bit          cpu_busy[int];
    logic [31:0] tm_pat[DEPTH];
    int          tm_dly[DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          t, dv;
    logic [31:0] rd;
    int          b_start, b_len;
    bit          b_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sequencer writes against the scoreboard, CPU accesses mirrored.
    exp_t e;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("c_rdata passthrough", c_rdata, m_rdata);
            if (c_wr_en || c_rd_en) begin
                chk("cpu mirror addr", {24'h0, m_addr}, {24'h0, c_addr});
                chk("cpu mirror wr_en", {31'h0, m_wr_en}, {31'h0, c_wr_en});
                chk("cpu mirror rd_en", {31'h0, m_rd_en}, {31'h0, c_rd_en});
                chk("cpu mirror wdata", m_wdata, c_wdata);
            end else if (m_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected seq write: got data 0x%08h at cycle %0d, expected none", m_wdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("seq write cycle", cyc, e.cyc);
                    chk("seq write data", m_wdata, e.dat);
                    chk("seq write addr", {24'h0, m_addr}, {24'h0, GPIO_DATA_OUT_OFS});
                    chk("seq write rd_en", {31'h0, m_rd_en}, 32'h0);
                end
            end
        end
    end

    // Reference timing: step k is written in the first CPU-free cycle at or after
    // its due time; the next step is due delay+2 cycles after that write.
    task automatic model_run(input int t0, input int len, input int nw, output int done_vis);
        int tt, st, last_t, last_st;
        tt = t0; last_t = t0; last_st = 0;
        for (int k = 0; k < nw; k++) begin
            st = k % (len + 1);
            while (cpu_busy.exists(tt)) tt++;
            exp_q.push_back('{tt, tm_pat[st]});
            last_t  = tt;
            last_st = st;
            tt      = tt + tm_dly[st] + 2;
        end
        done_vis = last_t + tm_dly[last_st] + 2;
    endtask

    task automatic sw(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        s_addr = a; s_wdata = d; s_wr_en = 1'b1;
        @(posedge clk); #1;
        s_wr_en = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic sw_at(input int target, input logic [7:0] a, input logic [31:0] d);
        wait_until(target);
        s_addr = a; s_wdata = d; s_wr_en = 1'b1;
        @(posedge clk); #1;
        s_wr_en = 1'b0;
    endtask

    task automatic sr(input logic [7:0] a, output logic [31:0] d);
        s_addr = a; s_rd_en = 1'b1;
        #1 d = s_rdata;
        s_rd_en = 1'b0;
    endtask

    task automatic load_table(input int n);
        sw(SEQ_IDX, 32'h0);
        for (int i = 0; i < n; i++) begin
            sw(SEQ_PAT, tm_pat[i]);
            sw(SEQ_DLY, 32'(tm_dly[i]));
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d writes still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string n, input logic b, input logic d, input int st);
        logic [31:0] v;
        sr(SEQ_STATUS, v);
        chk({n, " busy"}, {31'h0, v[STAT_BUSY]}, {31'h0, b});
        chk({n, " done"}, {31'h0, v[STAT_DONE]}, {31'h0, d});
        chk({n, " step"}, 32'(v[STAT_STEP +: 3]), 32'(st));
    endtask

    task automatic cpu_burst();
        wait_until(b_start);
        for (int i = 0; i < b_len; i++) begin
            c_wr_en = !b_rd; c_rd_en = b_rd;
            c_addr = 8'($urandom); c_wdata = $urandom;
            @(posedge clk); #1;
        end
        c_wr_en = 1'b0; c_rd_en = 1'b0;
    endtask

    task automatic set_base_table();
        tm_pat[0] = 32'hA; tm_pat[1] = 32'h5; tm_pat[2] = 32'hF;
        tm_dly[0] = 0;     tm_dly[1] = 3;     tm_dly[2] = 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int len;
        bit ie;
        rst = 1'b1; seq_trig = 1'b0;
        s_addr = '0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wdata = '0;
        c_addr = '0; c_wr_en = 1'b0; c_rd_en = 1'b0; c_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset m_wr_en", {31'h0, m_wr_en}, 32'h0);
        chk("reset m_addr", {24'h0, m_addr}, 32'h0);
        chk("reset m_wdata", m_wdata, 32'h0);
        chk("reset irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        sr(SEQ_CTRL, rd);   chk("reset CTRL", rd, 32'h0);
        sr(SEQ_STATUS, rd); chk("reset STATUS", rd, 32'h0);
        sr(SEQ_IDX, rd);    chk("reset IDX", rd, 32'h0);

        // Table load and readback
        set_base_table();
        load_table(3);
        sr(SEQ_IDX, rd); chk("IDX after 3 DLY writes", rd, 32'h3);
        sw(SEQ_IDX, 32'h1);
        sr(SEQ_PAT, rd); chk("PAT[1] readback", rd, 32'h5);
        sr(SEQ_DLY, rd); chk("DLY[1] readback", rd, 32'h3);

        // Single run with IE
        sw(SEQ_CTRL, 32'h209);
        t = cyc;
        model_run(t, 2, 3, dv);
        wait_drain(40, "run1 drain");
        wait_until(dv);
        check_status("run1", 1'b0, 1'b1, 2);
        chk("run1 irq", {31'h0, irq}, 32'h1);
        sw(SEQ_STATUS, 32'h2);
        check_status("run1 w1c", 1'b0, 1'b0, 2);
        chk("run1 w1c irq", {31'h0, irq}, 32'h0);

        // W1C in the same cycle done is set: set wins
        sw(SEQ_CTRL, 32'h209);
        t = cyc;
        model_run(t, 2, 3, dv);
        sw_at(dv - 1, SEQ_STATUS, 32'h2);
        wait_drain(40, "w1c race drain");
        wait_until(dv);
        check_status("w1c race", 1'b0, 1'b1, 2);
        sw(SEQ_STATUS, 32'h2);
        check_status("w1c second", 1'b0, 1'b0, 2);
        chk("w1c second irq", {31'h0, irq}, 32'h0);

        // Loop, then STOP during step 1 of the second pass
        sw(SEQ_CTRL, 32'h20B);
        t = cyc;
        model_run(t, 2, 5, dv);
        sw_at(t + 13, SEQ_CTRL, 32'h204);
        wait_drain(40, "loop drain");
        repeat (25) @(posedge clk);
        #1;
        sr(SEQ_STATUS, rd);
        chk("stop busy", {31'h0, rd[STAT_BUSY]}, 32'h0);
        chk("stop done", {31'h0, rd[STAT_DONE]}, 32'h0);
        chk("stop irq", {31'h0, irq}, 32'h0);

        // CPU holds the bus for 4 cycles at the first issue
        sw(SEQ_CTRL, 32'h201);
        t = cyc;
        for (int i = 0; i < 4; i++) cpu_busy[t + i] = 1'b1;
        model_run(t, 2, 3, dv);
        c_wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_addr = 8'($urandom); c_wdata = $urandom;
            @(posedge clk); #1;
        end
        c_wr_en = 1'b0;
        wait_drain(40, "contention drain");
        wait_until(dv);
        check_status("contention", 1'b0, 1'b1, 2);
        chk("contention irq (IE=0)", {31'h0, irq}, 32'h0);
        sw(SEQ_STATUS, 32'h2);

        // Reset during WAIT of step 1
        sw(SEQ_CTRL, 32'h209);
        t = cyc;
        model_run(t, 2, 2, dv);
        wait_until(t + 4);
        rst = 1'b1;
        #1;
        chk("rst m_wr_en", {31'h0, m_wr_en}, 32'h0);
        chk("rst irq", {31'h0, irq}, 32'h0);
        check_status("rst", 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_drain(5, "rst drain");
        load_table(3);
        sw(SEQ_CTRL, 32'h201);
        t = cyc;
        model_run(t, 2, 3, dv);
        wait_drain(40, "replay drain");
        wait_until(dv);
        check_status("replay", 1'b0, 1'b1, 2);
        sw(SEQ_STATUS, 32'h2);

        // Randomized tables with a random CPU burst
        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(DEPTH - 1, 0);
            for (int i = 0; i <= len; i++) begin
                tm_pat[i] = $urandom;
                tm_dly[i] = $urandom_range(5, 0);
            end
            load_table(len + 1);
            ie = 1'($urandom_range(1, 0));
            sw(SEQ_CTRL, (32'(len) << 8) | (32'(ie) << 3) | 32'h1);
            t = cyc;
            b_start = t + $urandom_range(6, 1);
            b_len   = $urandom_range(4, 1);
            b_rd    = 1'($urandom_range(1, 0));
            for (int i = 0; i < b_len; i++) cpu_busy[b_start + i] = 1'b1;
            model_run(t, len, len + 1, dv);
            fork
                cpu_burst();
            join_none
            wait_drain(300, "random drain");
            wait_until(dv);
            wait_until(b_start + b_len + 1);
            check_status("random", 1'b0, 1'b1, len);
            chk("random irq", {31'h0, irq}, {31'h0, ie});
            sw(SEQ_STATUS, 32'h2);
        end

        // Trigger start
        set_base_table();
        load_table(3);
`ifdef GPIO_SEQ_TRIG_EN
        sw(SEQ_CTRL, 32'h210);
        sr(SEQ_CTRL, rd); chk("ARM set", rd, 32'h210);
        seq_trig = 1'b1;
        t = cyc + 1;
        model_run(t, 2, 3, dv);
        @(posedge clk); #1;
        sr(SEQ_CTRL, rd); chk("ARM cleared by trigger", rd, 32'h200);
        seq_trig = 1'b0;
        @(posedge clk); #1;
        seq_trig = 1'b1;
        @(posedge clk); #1;
        seq_trig = 1'b0;
        wait_drain(40, "trigger drain");
        wait_until(dv);
        repeat (10) @(posedge clk);
        #1;
        check_status("trigger", 1'b0, 1'b1, 2);
        sw(SEQ_STATUS, 32'h2);
`else
        sw(SEQ_CTRL, 32'h010);
        sr(SEQ_CTRL, rd); chk("ARM ignored without trigger", rd, 32'h0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
